ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the send side of the PS/2 link whose receive side feeds PS2_byte.
//  Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard using the standard
//  inhibit/request-to-send sequence. It then checks the device ACK bit. Open-drain lines are driven only
//  through *_oe outputs; top level does: assign PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz (same for PS2_DAT).
// PARAMETERS
//  INHIBIT_CYCLES  6000    clk cycles CLK held low before request (120us @ 50MHz)
//  START_CYCLES    1000    clk cycles DAT held low with CLK low before CLK release (20us)
//  START_TIMEOUT   750000  max cycles from CLK release to first device falling edge (15ms)
//  BIT_TIMEOUT     100000  max cycles between successive device falling edges (2ms)
// PORTS
//  clk         in   1  system clock (CLOCK_50)
//  reset       in   1  asynchronous, active-low reset
//  cmd_data    in   8  byte to send; sampled on the cycle cmd_send is accepted
//  cmd_send    in   1  one-cycle request; ignored while busy=1
//  ps2_clk_in  in   1  raw PS2_CLK line level (asynchronous)
//  ps2_dat_in  in   1  raw PS2_DAT line level (asynchronous)
//  ps2_clk_oe  out  1  1 = pull PS2_CLK low
//  ps2_dat_oe  out  1  1 = pull PS2_DAT low
//  busy        out  1  high from accept through completion/error
//  done        out  1  one-cycle pulse: byte sent and ACK received
//  error       out  1  one-cycle pulse: missing ACK or timeout
// BEHAVIOUR
//  - Reset (async, reset=0): state IDLE; ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, error=0; lines released at once.
//  - Line inputs go through 2-flop synchronisers. fall = sync CLK 1 in previous cycle, 0 now.
//  - Frame: start(0), d[0]..d[7] LSB first, odd parity (= ~^cmd_data), stop(1 = released); device ACK(0).
//  - IDLE: on cmd_send, latch cmd_data and parity into an 11-bit shift reg; busy=1 next cycle -> INHIBIT.
//  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES -> START.
//  - START: clk_oe=1, dat_oe=1 for START_CYCLES. Then clk_oe=0, dat_oe held 1 (start bit) -> WAIT_DEV.
//  - WAIT_DEV/SHIFT: bit counter n=0..10 on each fall:
//      n=0..7 -> dat_oe = ~d[n]; n=8 -> dat_oe = ~parity; n=9 -> dat_oe=0 (stop);
//      n=10 -> sample sync DAT: 0 = ACK ok -> WAIT_IDLE; 1 -> ERROR.
//    Outputs update the cycle after fall is detected (≤3 clk after the line edge); well within the device low phase.
//  - WAIT_IDLE: wait until sync CLK=1 and DAT=1. Then pulse done for 1 cycle, busy=0 -> IDLE.
//  - ERROR: release both lines, pulse error for 1 cycle, busy=0 -> IDLE.
//  - done and error are never high together. No new byte is accepted in the cycle done/error pulses.
//  - cmd_send while busy: ignored, no queueing. cmd_send with cmd_send held high: one byte per accept.
//  - Device-to-host traffic seen while in IDLE is not interpreted; only the receiver acts on it.
//  - Counters are sized from the parameters ($clog2). They saturate and do not wrap.
// CONFIGURATION
//  PS2_HOST_TX_TIMEOUT_EN defined: in WAIT_DEV, cycle counter resets on each fall.
//    START_TIMEOUT applies before the first fall; BIT_TIMEOUT applies afterwards, WAIT_IDLE included.
//    Expiry -> ERROR.
//  Not defined: no timeouts; the block waits indefinitely for device clocks. Error arises only from missing ACK.
// TESTING
//  1 Reset asserted mid-frame (n=5): clk_oe=dat_oe=busy=0 immediately, no done/error; next send works.
//  2 Send 0xED with device model ACKing: bits sampled on rising edges = 0,1,0,1,1,0,1,1,1,1,1 (parity 1, stop 1);
//    done pulses once, error stays 0.
//  3 Send 0xF4: data LSB-first 0,0,1,0,1,1,1,1, parity 0; ACK -> done. Send 0x00: parity 1.
//  4 Device holds DAT high at ACK clock -> error pulse 1 cycle, done stays 0, lines released, busy=0.
//  5 cmd_send with 0xAA while busy sending 0xFF: only 0xFF is transmitted; one done.
//  6 PS2_HOST_TX_TIMEOUT_EN, device never clocks: error exactly START_TIMEOUT cycles after CLK release.
//    Same stimulus without the macro: busy stays 1.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard
// using the inhibit / request-to-send sequence, shifts the frame out on the
// device-generated clock and checks the device ACK bit.
//
// Both PS/2 lines are open-drain and are only ever pulled low through the
// *_oe outputs; the surrounding top level does
//   assign PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz;   (same for PS2_DAT)
//
// Frame on the wire: start(0), d[0]..d[7], odd parity, stop(1), device ACK(0).
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-low reset
//   cmd_data    in   [7:0] byte to send, sampled when cmd_send is accepted
//   cmd_send    in   one-cycle send request, ignored while busy
//   ps2_clk_in  in   raw PS2_CLK line level (asynchronous)
//   ps2_dat_in  in   raw PS2_DAT line level (asynchronous)
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
//   busy        out  high from accept through completion/error
//   done        out  one-cycle pulse: byte sent and ACK received
//   error       out  one-cycle pulse: missing ACK or timeout
//
// Build option
//   PS2_HOST_TX_TIMEOUT_EN  when defined, a stalled device is detected:
//     START_TIMEOUT cycles are allowed from CLK release to the first device
//     falling edge, BIT_TIMEOUT cycles between later edges and while waiting
//     for the bus to go idle after the ACK. Expiry ends the frame with error.
//     When undefined the block waits indefinitely for device clocks.
// ---------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int START_CYCLES   = 1000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_send,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // -------------------------------------------------------------------------
  // Counter sizing: one shared cycle counter covers the inhibit and start
  // phases and, when timeouts are built in, the device-clock watchdog.
  // -------------------------------------------------------------------------
  localparam int TOP_PHASE = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int TOP_WDOG  = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int CNT_TOP   = (TOP_PHASE > TOP_WDOG) ? TOP_PHASE : TOP_WDOG;
`else
  localparam int CNT_TOP   = TOP_PHASE;
`endif
  localparam int CW        = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam logic [CW-1:0] STO_LAST   = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] BTO_LAST   = CW'(BIT_TIMEOUT - 1);
`endif

  // FSM encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_DEV  = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // Odd parity over the data byte: the bit that makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  // Saturating increment; the counter parks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == {CW{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]    state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [3:0]    n_q,      n_d;       // device falling edges seen this frame
  logic [10:0]   sreg_q,   sreg_d;    // {stop, parity, d[7:0], start}
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic          error_q,  error_d;

  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;

  logic          clk_fall_s;
  logic          abort_s;

  assign clk_fall_s = clk_prev_q & ~clk_sync_q;

  // Two-flop synchronisers for both lines plus a delayed CLK copy for edge detect.
  // Idle lines are pulled up, so the flops reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
    end
  end

  // Next-state and output logic for the transmit sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    sreg_d   = sreg_q;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    abort_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        // A request landing in the done/error pulse cycle is dropped so each
        // completion is seen before the next frame starts.
        if (cmd_send && !done_q && !error_q) begin
          sreg_d   = {1'b1, odd_parity(cmd_data), cmd_data, 1'b0};
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          cnt_d    = {CW{1'b0}};
          n_d      = 4'd0;
          state_d  = ST_INHIBIT;
        end else begin
          state_d  = ST_IDLE;
        end
      end

      ST_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          // sreg_q[0] is the start bit (0): pulling DAT low is the request to send.
          dat_oe_d = ~sreg_q[0];
          cnt_d    = {CW{1'b0}};
          state_d  = ST_START;
        end else begin
          cnt_d    = sat_inc(cnt_q);
        end
      end

      ST_START: begin
        if (cnt_q == START_LAST) begin
          // Release CLK; DAT stays low as the start bit until the device clocks.
          clk_oe_d = 1'b0;
          cnt_d    = {CW{1'b0}};
          state_d  = ST_WAIT_DEV;
        end else begin
          cnt_d    = sat_inc(cnt_q);
        end
      end

      ST_WAIT_DEV: begin
        if (clk_fall_s) begin
          cnt_d = {CW{1'b0}};
          if (n_q == 4'd10) begin
            // Eleventh falling edge: the device should be holding DAT low (ACK).
            if (dat_sync_q == 1'b0) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              abort_s = 1'b1;
            end
          end else begin
            // Present the next bit while the device clock is low; it is
            // sampled by the device on the following rising edge.
            dat_oe_d = ~sreg_q[1];
            sreg_d   = {1'b1, sreg_q[10:1]};
            n_d      = n_q + 4'd1;
          end
        end else begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
          // Before the first edge the longer start allowance applies.
          if (cnt_q == ((n_q == 4'd0) ? STO_LAST : BTO_LAST)) begin
            abort_s = 1'b1;
          end else begin
            cnt_d   = sat_inc(cnt_q);
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end

      ST_WAIT_IDLE: begin
        // The frame is complete only once the device has let go of both lines.
        if (clk_sync_q && dat_sync_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
`ifdef PS2_HOST_TX_TIMEOUT_EN
          if (cnt_q == BTO_LAST) begin
            abort_s = 1'b1;
          end else begin
            cnt_d   = sat_inc(cnt_q);
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end

      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Missing ACK or watchdog expiry: free the bus and report.
    if (abort_s) begin
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      error_d  = 1'b1;
      n_d      = 4'd0;
      state_d  = ST_IDLE;
    end else begin
      error_d  = 1'b0;
    end
  end

  // Registered state and outputs; reset releases both lines immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CW{1'b0}};
      n_q      <= 4'd0;
      sreg_q   <= 11'h7FF;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      sreg_q   <= sreg_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Testbench for ps2_host_tx: a keyboard-side device model generates the PS/2
// clock and records the bits the host presents; a scoreboard holds the
// frame/outcome predicted by a reference model and a monitor compares them
// whenever the DUT pulses done or error.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int STC  = 8;
  localparam int STO  = 300;
  localparam int BTO  = 200;
  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_send = 1'b0;
  logic       clk_oe, dat_oe, busy, done, error;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       clk_line, dat_line;

  // Wired-AND open-drain bus with pull-ups.
  assign clk_line = ~(clk_oe | dev_clk_low);
  assign dat_line = ~(dat_oe | dev_dat_low);

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_CYCLES  (STC),
    .START_TIMEOUT (STO),
    .BIT_TIMEOUT   (BTO)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .cmd_data  (cmd_data),
    .cmd_send  (cmd_send),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(clk_oe),
    .ps2_dat_oe(dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  typedef struct {
    logic [10:0] frame;
    bit          is_err;
    bit          chk_frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] cap_q[$];
  int          tests = 0;
  int          fails = 0;
  bit          model_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference frame as the device should see it, bit 0 first on the wire.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    logic [10:0] f;
    int ones;
    ones = 0;
    f = 11'h000;
    for (int k = 1; k <= 8; k++) begin
      f[k]  = ((int'(d) >> (k - 1)) % 2) == 1;
      ones += ((int'(d) >> (k - 1)) % 2);
    end
    f[0]  = 1'b0;
    f[9]  = (ones % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Monitor: pops the scoreboard whenever done or error pulses.
  exp_t mon_e;
  logic [10:0] mon_f;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (done && error) check("done_error_exclusive", {31'd0, done & error}, 32'd0);
        if (done || error) begin
          if (exp_q.size() == 0) begin
            check("unexpected_response", {30'd0, done, error}, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("outcome_error", {31'd0, error}, {31'd0, mon_e.is_err});
            check("outcome_done", {31'd0, done}, {31'd0, ~mon_e.is_err});
            check("busy_cleared", {31'd0, busy}, 32'd0);
            check("lines_released", {30'd0, clk_oe, dat_oe}, 32'd0);
            if (mon_e.chk_frame) begin
              check("frame_captured_count", cap_q.size(), 32'd1);
              if (cap_q.size() > 0) begin
                mon_f = cap_q.pop_front();
                check("frame_bits", {21'd0, mon_f}, {21'd0, mon_e.frame});
              end
            end
            model_busy = 1'b0;
          end
        end
      end
    end
  end

  // Issue a one-cycle send request; the model accepts it only when idle.
  task automatic issue(input logic [7:0] d, input bit ack, input bit score);
    @(negedge clk);
    cmd_data = d;
    cmd_send = 1'b1;
    if (!model_busy) begin
      if (score) exp_q.push_back('{ref_frame(d), ~ack, 1'b1});
      model_busy = 1'b1;
    end
    @(negedge clk);
    cmd_send = 1'b0;
    check("busy_after_send", {31'd0, busy}, 32'd1);
  endtask

  // Device model: waits for request-to-send, then clocks 11 bits, sampling
  // DAT while CLK is high before each falling edge, and ACKs on the last one.
  task automatic dev_frame(input bit ack, input int stop_at, output logic [10:0] got);
    int w;
    got = 11'h000;
    w = 0;
    while (!(clk_oe === 1'b0 && dat_oe === 1'b1) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("request_to_send", {30'd0, clk_oe, dat_oe}, 32'd1);
    if (!(clk_oe === 1'b0 && dat_oe === 1'b1)) return;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 11; k++) begin
      repeat (HALF) @(negedge clk);
      got[k] = dat_line;
      if (k == 10) begin
        cap_q.push_back(got);
        if (ack) dev_dat_low = 1'b1;
        repeat (3) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (k == stop_at) return;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    dev_dat_low = 1'b0;
  endtask

  // Bounded wait for all scoreboard entries to be consumed.
  task automatic wait_resp();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 600) begin
      @(negedge clk);
      w++;
    end
    check("response_within_bound", exp_q.size(), 32'd0);
    if (exp_q.size() != 0) begin
      exp_q.delete();
      cap_q.delete();
      model_busy = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic xact(input logic [7:0] d, input bit ack, output logic [10:0] got);
    issue(d, ack, 1'b1);
    dev_frame(ack, 99, got);
    wait_resp();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    cap_q.delete();
    model_busy  = 1'b0;
    dev_clk_low = 1'b0;
    dev_dat_low = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [10:0] got;
  int          t0, w;
  bit          seen_hi;
  logic [7:0]  rd;
  bit          rack;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'd0, clk_oe, dat_oe, busy, done, error}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Set-LEDs command, wire order 0,1,0,1,1,0,1,1,1,1,1.
    xact(8'hED, 1'b1, got);
    check("frame_ED_wire", {21'd0, got}, 32'h7DA);
    // Enable command: parity 0.
    xact(8'hF4, 1'b1, got);
    check("frame_F4_wire", {21'd0, got}, 32'h5E8);
    // All-zero byte: parity 1.
    xact(8'h00, 1'b1, got);
    check("frame_00_wire", {21'd0, got}, 32'h600);
    // Missing ACK.
    xact(8'h5A, 1'b0, got);
    check("idle_after_nack", {29'd0, busy, clk_oe, dat_oe}, 32'd0);

    // Second request while busy is ignored.
    issue(8'hFF, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    issue(8'hAA, 1'b1, 1'b1);
    dev_frame(1'b1, 99, got);
    wait_resp();
    seen_hi = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (clk_oe) seen_hi = 1'b1;
    end
    check("no_second_frame", {31'd0, seen_hi}, 32'd0);

    // Randomised bytes with occasional missing ACK.
    for (int i = 0; i < 8; i++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 4) != 0);
      xact(rd, rack, got);
    end

    // Reset mid-frame after the sixth device falling edge.
    issue(8'h3C, 1'b1, 1'b1);
    dev_frame(1'b1, 5, got);
    repeat (4) @(negedge clk);
    pulse_reset();
    check("reset_midframe", {27'd0, clk_oe, dat_oe, busy, done, error}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("quiet_after_reset", {29'd0, busy, done, error}, 32'd0);
    xact(8'hF4, 1'b1, got);
    check("frame_after_reset", {21'd0, got}, 32'h5E8);

    // Device never clocks.
    issue(8'h55, 1'b1, 1'b0);
    w = 0;
    while (clk_oe !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    w = 0;
    while (clk_oe !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    t0 = cyc;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    exp_q.push_back('{11'h000, 1'b1, 1'b0});
    w = 0;
    while (error !== 1'b1 && w < STO + 50) begin @(negedge clk); w++; end
    check("start_timeout_cycles", cyc - t0, STO);
    wait_resp();
`else
    repeat (STO + 50) @(negedge clk);
    check("no_timeout_busy", {30'd0, busy, clk_oe}, 32'd2);
    pulse_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
